// File: rtl/audiodac_i2s_rx.sv
// I2S receiver for the audio DAC: oversamples bclk/ws/sd in the clk_i domain and deserializes
// one channel. Each sample goes to the FIFO as offset-binary over a 4-phase rdy/ack handshake.
module audiodac_i2s_rx #(
    parameter int unsigned AUDIO_WIDTH = 16,
    parameter int unsigned CNT_WIDTH   = 6
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   i2s_bclk_i,
    input  logic                   i2s_ws_i,
    input  logic                   i2s_sd_i,
    input  logic                   chan_sel_i,
    input  logic                   ovr_clr_i,
    output logic [AUDIO_WIDTH-1:0] fifo_data_o,
    output logic                   fifo_rdy_o,
    input  logic                   fifo_ack_i,
    output logic                   ovr_o
);

    localparam logic [AUDIO_WIDTH-1:0] MIDSCALE = {1'b1, {(AUDIO_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } hs_state_t;

    logic [2:0]             bclk_sync;
    logic [1:0]             ws_sync;
    logic [1:0]             sd_sync;
    logic                   bclk_rise_c;
    logic                   ws_s;
    logic                   sd_s;
    logic                   ws_q;
    logic                   locked;
    logic [AUDIO_WIDTH-1:0] shreg;
    logic [AUDIO_WIDTH-1:0] shreg_bit_c;
    logic [AUDIO_WIDTH-1:0] word_q;
    logic [CNT_WIDTH-1:0]   bit_cnt;
    logic                   emit_q;
    hs_state_t              state;

    // Two-flop synchronizers; the third bclk flop is the edge-detect delay.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bclk_sync <= '0;
            ws_sync   <= '0;
            sd_sync   <= '0;
        end else begin
            bclk_sync <= {bclk_sync[1:0], i2s_bclk_i};
            ws_sync   <= {ws_sync[0], i2s_ws_i};
            sd_sync   <= {sd_sync[0], i2s_sd_i};
        end
    end

    assign bclk_rise_c = bclk_sync[1] & ~bclk_sync[2];
    assign ws_s        = ws_sync[1];
    assign sd_s        = sd_sync[1];

    // Shift register with the current bit dropped into its MSB-first slot position.
    always_comb begin
        shreg_bit_c = shreg;
        for (int unsigned i = 0; i < AUDIO_WIDTH; i++) begin
            if (32'(bit_cnt) == AUDIO_WIDTH - 1 - i) begin
                shreg_bit_c[i] = sd_s;
            end
        end
    end

    // Deserializer: a ws change marks the bit just sampled as the last of the ending slot.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ws_q    <= 1'b0;
            locked  <= 1'b0;
            shreg   <= '0;
            bit_cnt <= '0;
            word_q  <= '0;
            emit_q  <= 1'b0;
        end else begin
            emit_q <= 1'b0;
            if (bclk_rise_c) begin
                ws_q <= ws_s;
                if (ws_s != ws_q) begin
                    word_q  <= shreg_bit_c;
                    emit_q  <= locked && (ws_q == chan_sel_i);
                    locked  <= 1'b1;
                    shreg   <= '0;
                    bit_cnt <= '0;
                end else begin
                    shreg <= shreg_bit_c;
                    if (bit_cnt != '1) begin
                        bit_cnt <= bit_cnt + CNT_WIDTH'(1);
                    end
                end
            end
        end
    end

    // FIFO handshake; any word completed while a request is outstanding is dropped.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= ST_IDLE;
            fifo_data_o <= MIDSCALE;
            fifo_rdy_o  <= 1'b0;
            ovr_o       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (emit_q) begin
                        fifo_data_o <= {~word_q[AUDIO_WIDTH-1], word_q[AUDIO_WIDTH-2:0]};
                        fifo_rdy_o  <= 1'b1;
                        state       <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (fifo_ack_i) begin
                        fifo_rdy_o <= 1'b0;
                        state      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!fifo_ack_i) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    fifo_rdy_o <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase

            if (emit_q && (state != ST_IDLE)) begin
                ovr_o <= 1'b1;
            end else if (ovr_clr_i) begin
                ovr_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_audiodac_i2s_rx.sv
// Bench for audiodac_i2s_rx: an I2S frame generator feeds a slot-level model that predicts
// every FIFO word and its arrival cycle; one compare process checks rdy/data/ovr each cycle.
module tb_audiodac_i2s_rx;

    logic        clk;
    logic        rst_n;
    logic        bclk;
    logic        ws;
    logic        sd;
    logic        chan_sel;
    logic        ovr_clr;
    logic [15:0] fifo_data;
    logic        fifo_rdy;
    logic        fifo_ack;
    logic        ovr;

    audiodac_i2s_rx #(.AUDIO_WIDTH(16), .CNT_WIDTH(6)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .i2s_bclk_i (bclk),
        .i2s_ws_i   (ws),
        .i2s_sd_i   (sd),
        .chan_sel_i (chan_sel),
        .ovr_clr_i  (ovr_clr),
        .fifo_data_o(fifo_data),
        .fifo_rdy_o (fifo_rdy),
        .fifo_ack_i (fifo_ack),
        .ovr_o      (ovr)
    );

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] got_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          clr_due = -1;
    logic        ack_e = 1'b0;
    logic        clr_e = 1'b0;
    logic        exp_rdy = 1'b0;
    logic        exp_ovr = 1'b0;
    logic [15:0] exp_data = 16'h8000;
    logic        rdy_prev = 1'b0;
    bit          ack_hold = 1'b0;
    bit          clr_on_end = 1'b0;
    bit          m_locked = 1'b0;
    bit          m_ws_prev = 1'b0;
    logic [63:0] m_bits = '0;
    int          m_cnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Slot of n MSB-first bits -> top 16 bits left-justified, then offset-binary.
    function automatic logic [15:0] to_fifo(input logic [63:0] bits, input int n);
        logic [63:0] top;
        if (n >= 16) top = bits >> (n - 16);
        else         top = bits << (16 - n);
        return top[15:0] + 16'h8000;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        exp_rdy   = 1'b0;
        exp_ovr   = 1'b0;
        exp_data  = 16'h8000;
        m_locked  = 1'b0;
        m_ws_prev = 1'b0;
        m_bits    = '0;
        m_cnt     = 0;
    endtask

    task automatic model_rise(input bit w, input bit d, input int due);
        exp_t e;
        m_bits = {m_bits[62:0], d};
        m_cnt++;
        if (w != m_ws_prev) begin
            if (m_locked && (m_ws_prev == chan_sel)) begin
                e.data = to_fifo(m_bits, m_cnt);
                e.due  = due;
                exp_q.push_back(e);
                if (clr_on_end) begin
                    clr_due    = due;
                    clr_on_end = 1'b0;
                end
            end
            m_locked = 1'b1;
            m_bits   = '0;
            m_cnt    = 0;
        end
        m_ws_prev = w;
    endtask

    // One bclk period: data changes with bclk low, sampled on the rising edge.
    task automatic tx_bit(input bit w, input bit d);
        @(posedge clk); #3;
        bclk = 1'b0; ws = w; sd = d;
        @(posedge clk); @(posedge clk); #3;
        bclk = 1'b1;
        model_rise(w, d, cyc + 4);
        @(posedge clk); @(posedge clk);
    endtask

    // I2S slot: ws switches one bit early, so the LSB goes out with the next channel's ws.
    task automatic send_slot(input bit ch, input int width, input logic [31:0] val);
        for (int i = width - 1; i >= 1; i--) tx_bit(ch, val[i]);
        tx_bit(!ch, val[0]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic wait_rdy(input int budget);
        int n = 0;
        while (!fifo_rdy && n < budget) begin
            @(posedge clk); #3;
            n++;
        end
        check("wait_rdy", 32'(fifo_rdy), 32'd1);
    endtask

    function automatic logic [31:0] got_at(input int idx);
        return (idx < got_q.size()) ? 32'(got_q[idx]) : 32'hDEAD_BEEF;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            ack_e = fifo_ack;
            clr_e = ovr_clr;
        end
    end

    // FIFO side: ack two cycles into a request unless stalled, drop ack once rdy falls.
    initial begin
        int rcnt;
        rcnt     = 0;
        fifo_ack = 1'b0;
        forever begin
            @(posedge clk); #3;
            if (!fifo_rdy) begin
                fifo_ack = 1'b0;
                rcnt     = 0;
            end else if (!ack_hold) begin
                rcnt++;
                if (rcnt == 2) fifo_ack = 1'b1;
            end
        end
    end

    initial begin
        ovr_clr = 1'b0;
        forever begin
            @(posedge clk); #3;
            ovr_clr = (cyc + 1 == clr_due);
        end
    end

    // Every-cycle compare of the FIFO-side outputs against the model.
    initial begin
        exp_t e;
        bit   busy;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                busy = exp_rdy;
                if (clr_e) exp_ovr = 1'b0;
                if (exp_rdy && ack_e) exp_rdy = 1'b0;
                if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                    e = exp_q.pop_front();
                    if (busy) exp_ovr = 1'b1;
                    else begin
                        exp_rdy  = 1'b1;
                        exp_data = e.data;
                    end
                end
            end
            check("rdy", 32'(fifo_rdy), 32'(exp_rdy));
            check("data", 32'(fifo_data), 32'(exp_data));
            check("ovr", 32'(ovr), 32'(exp_ovr));
            if (fifo_rdy && !rdy_prev) got_q.push_back(fifo_data);
            rdy_prev = fifo_rdy;
        end
    end

    initial begin
        rst_n = 1'b0; bclk = 1'b0; ws = 1'b0; sd = 1'b0; chan_sel = 1'b0;
        model_reset();

        // Reset, then release with bclk idle.
        idle(3);
        check("reset_data", 32'(fifo_data), 32'h8000);
        check("reset_rdy", 32'(fifo_rdy), 32'd0);
        check("reset_ovr", 32'(ovr), 32'd0);
        rst_n = 1'b1;
        idle(20);
        check("idle_data", 32'(fifo_data), 32'h8000);
        check("idle_rdy", 32'(fifo_rdy), 32'd0);

        // 32-bit slots, left channel.
        got_q.delete();
        repeat (3) begin
            send_slot(1'b0, 32, 32'h1234_5A5A);
            send_slot(1'b1, 32, 32'hABCD_0F0F);
        end
        idle(8);
        check("left_count", 32'(got_q.size()), 32'd2);
        check("left_word0", got_at(0), 32'h9234);
        check("left_word1", got_at(1), 32'h9234);

        // Same stream, right channel.
        chan_sel = 1'b1;
        got_q.delete();
        repeat (2) begin
            send_slot(1'b0, 32, 32'h1234_5A5A);
            send_slot(1'b1, 32, 32'hABCD_0F0F);
        end
        idle(8);
        check("right_count", 32'(got_q.size()), 32'd2);
        check("right_word0", got_at(0), 32'h2BCD);

        // Stream starting mid-slot after reset: partial word must be discarded.
        rst_n = 1'b0; chan_sel = 1'b0;
        model_reset();
        idle(2);
        rst_n = 1'b1;
        idle(3);
        got_q.delete();
        for (int i = 0; i < 5; i++) tx_bit(1'b0, 1'b1);
        tx_bit(1'b1, 1'b1);
        send_slot(1'b1, 16, 32'h5555);
        send_slot(1'b0, 16, 32'h0F0F);
        send_slot(1'b1, 16, 32'h1111);
        idle(8);
        check("lock_count", 32'(got_q.size()), 32'd1);
        check("lock_word0", got_at(0), 32'h8F0F);

        // Short slot and extreme values.
        got_q.delete();
        send_slot(1'b0, 12, 32'hFFF);
        send_slot(1'b1, 12, 32'h123);
        send_slot(1'b0, 16, 32'h8000);
        send_slot(1'b1, 16, 32'h0001);
        send_slot(1'b0, 16, 32'h7FFF);
        send_slot(1'b1, 16, 32'h0000);
        idle(8);
        check("short_count", 32'(got_q.size()), 32'd3);
        check("short_fff", got_at(0), 32'h7FF0);
        check("min_value", got_at(1), 32'h0000);
        check("max_value", got_at(2), 32'hFFFF);

        // Overrun with the FIFO stalled for three frames.
        ack_hold = 1'b1;
        got_q.delete();
        send_slot(1'b0, 16, 32'h4321);
        send_slot(1'b1, 16, 32'h0000);
        send_slot(1'b0, 16, 32'h1111);
        send_slot(1'b1, 16, 32'h0000);
        idle(4);
        check("ovr_set", 32'(ovr), 32'd1);
        check("ovr_held_data", 32'(fifo_data), 32'hC321);
        check("ovr_held_rdy", 32'(fifo_rdy), 32'd1);
        clr_on_end = 1'b1;
        send_slot(1'b0, 16, 32'h2222);
        send_slot(1'b1, 16, 32'h0000);
        idle(4);
        check("ovr_set_wins", 32'(ovr), 32'd1);
        clr_due = cyc + 3;
        idle(6);
        check("ovr_cleared", 32'(ovr), 32'd0);
        ack_hold = 1'b0;
        idle(8);
        check("ovr_drained_rdy", 32'(fifo_rdy), 32'd0);
        check("ovr_count", 32'(got_q.size()), 32'd1);
        check("ovr_word0", got_at(0), 32'hC321);

        // Reset during an outstanding request.
        ack_hold = 1'b1;
        send_slot(1'b0, 16, 32'h2222);
        send_slot(1'b1, 16, 32'h0000);
        wait_rdy(50);
        @(posedge clk); #3;
        rst_n = 1'b0; bclk = 1'b0; ws = 1'b0; sd = 1'b0;
        model_reset();
        #1;
        check("midrst_rdy", 32'(fifo_rdy), 32'd0);
        check("midrst_data", 32'(fifo_data), 32'h8000);
        ack_hold = 1'b0;
        idle(3);
        rst_n = 1'b1;
        got_q.delete();
        send_slot(1'b0, 16, 32'h0001);
        send_slot(1'b1, 16, 32'h0000);
        send_slot(1'b0, 16, 32'h7000);
        send_slot(1'b1, 16, 32'h0000);
        idle(8);
        check("relock_count", 32'(got_q.size()), 32'd1);
        check("relock_word0", got_at(0), 32'hF000);
        check("pending_words", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/audiodac_i2s_rx.md
Name: audiodac_i2s_rx

Overview:
- Serial audio receiver that sits directly upstream of the audio FIFO's write interface.
- Oversamples an external I2S bit clock, word select and data in the clk_i domain, and deserializes the selected channel.
- Converts each sample from two's complement to offset-binary (midscale = 0 level).
- Presents each sample to the FIFO over a 4-phase rdy/ack handshake, and flags samples dropped while a handshake is still pending.

Parameters:
- AUDIO_WIDTH, 16, sample width delivered to the FIFO; slot bits beyond this are discarded.
- CNT_WIDTH, 6, width of the per-slot bit counter; it saturates, so slots of up to 2^CNT_WIDTH-1 bits are supported.

Ports:
- clk_i  in  1  system clock (same clock as the FIFO).
- rst_n_i  in  1  asynchronous, active-low reset.
- i2s_bclk_i  in  1  external I2S bit clock, asynchronous to clk_i.
- i2s_ws_i  in  1  word select: 0 = left, 1 = right; asynchronous.
- i2s_sd_i  in  1  serial data, MSB first; asynchronous.
- chan_sel_i  in  1  channel forwarded: 0 = left, 1 = right; quasi-static.
- ovr_clr_i  in  1  synchronous clear of ovr_o.
- fifo_data_o  out  AUDIO_WIDTH  offset-binary sample to the FIFO.
- fifo_rdy_o  out  1  sample valid (4-phase request).
- fifo_ack_i  in  1  FIFO acknowledge (4-phase).
- ovr_o  out  1  sticky overrun flag.

Behaviour:
- Reset values (asynchronous): fifo_data_o = {1'b1, zeros} (midscale), fifo_rdy_o = 0, ovr_o = 0.
  - Also cleared: sync flops, shift register, bit counter, handshake FSM, and the locked flag.
- Input synchronization:
  - bclk, ws and sd each pass through 2 flops.
  - A third bclk flop provides rising-edge detect (bclk_rise = sync & ~del).
  - bclk high and low phases must each be ≥ 2 clk_i periods; the bench respects this.
- On each bclk_rise:
  - Sample ws_s and sd_s; ws_q holds ws from the previous rise.
  - If bit_cnt < AUDIO_WIDTH: write sd_s into shreg[AUDIO_WIDTH-1-bit_cnt].
  - bit_cnt increments, saturating at all-ones.
- Word end: at a rise with ws_s != ws_q, the bit sampled at that rise is the last bit of the ending slot (I2S one-bit delay).
  - The word is complete including that bit; its channel is ws_q.
  - In the next cycle: shreg cleared, bit_cnt = 0. The next rise carries the new slot's MSB.
- Short and long slots:
  - Slots shorter than AUDIO_WIDTH are left-justified, with unfilled LSBs = 0.
  - Longer slots keep only the top AUDIO_WIDTH bits.
- Lock: after reset, locked = 0 and words are discarded. The first ws transition sets locked = 1.
  - That first transition's partial word is discarded; the first emitted word is the next full slot.
- Emit: a completed, locked word with channel == chan_sel_i is emitted.
  - Converted value = {~w[AUDIO_WIDTH-1], w[AUDIO_WIDTH-2:0]}.
  - Latency: fifo_rdy_o rises 4 clk_i edges after the pin-level bclk rise carrying the last bit (2 sync + edge detect + output register).
- Handshake FSM:
  - IDLE: on emit, load fifo_data_o, set fifo_rdy_o = 1, go to REQ.
  - REQ: hold fifo_rdy_o = 1 and fifo_data_o stable until fifo_ack_i = 1, then set fifo_rdy_o = 0 and go to WAIT.
  - WAIT: when fifo_ack_i = 0, go to IDLE.
  - fifo_data_o changes only on an IDLE→REQ transition; it holds its last value otherwise.
- Overrun:
  - An emit while in REQ or WAIT drops the new word and sets ovr_o = 1.
  - ovr_o stays set until ovr_clr_i = 1.
  - If the set and the clear occur in the same cycle, set wins.
  - An emit coinciding with the WAIT→IDLE transition is still dropped (no same-cycle reuse).
- chan_sel_i is sampled at word end. Changing it mid-slot affects only the next completed word.
- Asserting rst_n_i mid-word or mid-handshake immediately returns all state to reset values.
  - After reset release, the block relocks on the next ws transition.
- A bclk stuck high or low means no words and no handshake activity; the FSM holds its state.

Test Plan:
- Reset: hold rst_n_i = 0 → fifo_data_o = 16'h8000, fifo_rdy_o = 0, ovr_o = 0. Release with no bclk → outputs unchanged.
- Left-channel receive: chan_sel_i = 0, 32-bit slots, left = 16'h1234, right = 16'hABCD; FIFO model acks 2 cycles after rdy.
  - After lock → fifo_data_o = 16'h9234 with rdy asserted exactly once per frame.
  - The right word is never emitted. Repeat with chan_sel_i = 1 → 16'h2BCD.
- Lock and alignment: start the stream mid-slot right after reset → the first partial word is discarded, and the first emitted value is the first complete selected slot.
- Short slot: 12-bit slots, left = 12'hFFF → fifo_data_o = 16'h7FF0. Extreme values: 16'h8000 → 16'h0000, 16'h7FFF → 16'hFFFF.
- Overrun: hold fifo_ack_i = 0 for 3 frames → the first word stays on fifo_data_o and ovr_o = 1.
  - Then pulse ovr_clr_i together with a new drop event → ovr_o remains 1.
  - A later ovr_clr_i alone → ovr_o = 0.
- Reset mid-handshake: assert rst_n_i while fifo_rdy_o = 1 → immediately rdy = 0 and data = 16'h8000. After release, normal operation resumes after a ws transition.
